// File: rtl/arashi_wrr_sched.sv
// arashi_wrr_sched: weighted round-robin drain of per-thread cache entries into sequential memory
module arashi_wrr_sched #(
  parameter int MEM_WIDTH        = 10,
  parameter int THREAD_NUM_WIDTH = 2,
  parameter int WEIGHT_WIDTH     = 4,
  localparam int THREAD_NUM      = 1 << THREAD_NUM_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [THREAD_NUM-1:0]              avail,
  input  logic [THREAD_NUM*WEIGHT_WIDTH-1:0] weight_in,
  input  logic                               mem_ready,
  input  logic                               mem_clr,
  output logic [THREAD_NUM_WIDTH-1:0]        toread,
  output logic                               rcache,
  output logic [MEM_WIDTH-1:0]               waddr,
  output logic                               mem_full,
  output logic                               busy
);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_nxt;
  logic [THREAD_NUM_WIDTH-1:0] ptr, ptr_nxt, toread_nxt, hit, idx;
  logic [WEIGHT_WIDTH-1:0] credit, credit_nxt, hit_weight;
  logic [MEM_WIDTH:0] count;
  logic found, fire;
  assign waddr    = count[MEM_WIDTH-1:0];
  assign mem_full = count[MEM_WIDTH];
  assign busy     = state == BURST;
  assign fire     = busy && avail[toread] && mem_ready && !mem_full && !mem_clr && !rst;
  assign rcache   = fire;
  assign hit_weight = weight_in[hit*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  // first thread with data, searching upward from the one after the last grant
  always_comb begin
    found = 1'b0;
    hit   = ptr;
    idx   = ptr;
    for (int i = 1; i <= THREAD_NUM; i++) begin
      idx = ptr + THREAD_NUM_WIDTH'(i);
      if (!found && avail[idx]) begin
        found = 1'b1;
        hit   = idx;
      end
    end
  end
  // grant in IDLE; in BURST leave on exhausted credit or drained thread, otherwise spend credit per pop
  always_comb begin
    state_nxt  = state;
    toread_nxt = toread;
    ptr_nxt    = ptr;
    credit_nxt = credit;
    if (state == IDLE) begin
      if (found && !mem_full) begin
        state_nxt  = BURST;
        toread_nxt = hit;
        credit_nxt = (hit_weight == '0) ? WEIGHT_WIDTH'(1) : hit_weight;
      end
    end else if (!avail[toread] || (fire && credit == WEIGHT_WIDTH'(1))) begin
      state_nxt  = IDLE;
      ptr_nxt    = toread;
      credit_nxt = '0;
    end else if (fire) begin
      credit_nxt = credit - WEIGHT_WIDTH'(1);
    end
  end
  // scheduler state and saturating write counter; clear wins over a write
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      toread <= '0;
      ptr    <= THREAD_NUM_WIDTH'(THREAD_NUM - 1);
      credit <= '0;
      count  <= '0;
    end else begin
      state  <= state_nxt;
      toread <= toread_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
      count  <= mem_clr ? '0 : fire ? count + 1'b1 : count;
    end
  end
endmodule

// File: tb/tb_arashi_wrr_sched.sv
// tb_arashi_wrr_sched: directed scoreboard bench for the weighted round-robin scheduler
module tb_arashi_wrr_sched;
  logic clk = 1'b0, rst, mem_ready, mem_clr, rcache, mem_full, busy;
  logic [3:0] avail, waddr;
  logic [15:0] weight_in;
  logic [1:0] toread;
  typedef struct packed {logic [1:0] t; logic [3:0] a;} exp_t;
  exp_t q[$];
  exp_t e;
  int total = 0, bad = 0;

  arashi_wrr_sched #(.MEM_WIDTH(4), .THREAD_NUM_WIDTH(2), .WEIGHT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .avail(avail), .weight_in(weight_in), .mem_ready(mem_ready),
    .mem_clr(mem_clr), .toread(toread), .rcache(rcache), .waddr(waddr),
    .mem_full(mem_full), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // every pop presented by the DUT is matched against the next expected (thread, address)
  always @(negedge clk) begin
    if (rcache === 1'b1) begin
      if (q.size() == 0) chk("unexpected_fire", 1, 0);
      else begin
        e = q.pop_front();
        chk("fire_thread", 32'(toread), 32'(e.t));
        chk("fire_waddr", 32'(waddr), 32'(e.a));
      end
    end
  end

  task automatic push(input int t, input int a0, input int n);
    for (int k = 0; k < n; k++) q.push_back({2'(t), 4'(a0 + k)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic exp_rc, input string name);
    @(negedge clk);
    chk(name, 32'(rcache), 32'(exp_rc));
    step();
  endtask

  task automatic run(input logic [31:0] pat, input int n, input string name);
    for (int i = 0; i < n; i++) cyc(pat[n-1-i], name);
  endtask

  task automatic set_w(input int w0, input int w1, input int w2, input int w3);
    weight_in = {4'(w3), 4'(w2), 4'(w1), 4'(w0)};
  endtask

  task automatic do_reset();
    rst = 1'b1; avail = '0; mem_ready = 1'b1; mem_clr = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; avail = '0; weight_in = '0; mem_ready = 1'b1; mem_clr = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_rcache", 32'(rcache), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_waddr", 32'(waddr), 0);
      chk("rst_full", 32'(mem_full), 0);
      chk("rst_toread", 32'(toread), 0);
      step();
    end
    rst = 1'b0;
    avail = 4'b0010; set_w(0, 3, 0, 0);
    push(1, 0, 6);
    run(32'b01110111, 8, "t2_pattern");
    avail = '0;
    cyc(1'b0, "t2_idle");
    chk("t2_waddr", 32'(waddr), 6);

    do_reset();
    avail = 4'b1111; set_w(1, 1, 1, 1);
    for (int k = 0; k < 5; k++) push(k % 4, k, 1);
    run(32'b0101010101, 10, "t3_pattern");

    do_reset();
    avail = 4'b0100; set_w(0, 0, 4, 0);
    push(2, 0, 4);
    run(32'b011, 3, "t4_pre");
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall_rcache", 32'(rcache), 0);
      chk("t4_stall_busy", 32'(busy), 1);
      chk("t4_stall_waddr", 32'(waddr), 2);
      step();
    end
    mem_ready = 1'b1;
    run(32'b11, 2, "t4_resume");
    avail = '0;
    @(negedge clk);
    chk("t4_end_busy", 32'(busy), 0);
    chk("t4_end_rcache", 32'(rcache), 0);
    step();

    do_reset();
    avail = 4'b1111; set_w(4, 4, 4, 4);
    for (int b = 0; b < 4; b++) push(b, 4 * b, 4);
    for (int c = 0; c < 20; c++) cyc(c % 5 != 0, "t5_fill");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_full_rcache", 32'(rcache), 0);
      chk("t5_full_flag", 32'(mem_full), 1);
      chk("t5_full_busy", 32'(busy), 0);
      step();
    end
    mem_clr = 1'b1;
    cyc(1'b0, "t5_clr");
    mem_clr = 1'b0;
    @(negedge clk);
    chk("t5_clr_waddr", 32'(waddr), 0);
    chk("t5_clr_full", 32'(mem_full), 0);
    chk("t5_clr_rcache", 32'(rcache), 0);
    step();
    push(0, 0, 4);
    run(32'b1111, 4, "t5_resume");

    do_reset();
    avail = 4'b1101; set_w(5, 0, 2, 3);
    push(0, 0, 1); push(2, 1, 2); push(3, 3, 1);
    run(32'b01, 2, "t6_first");
    avail = 4'b1100;
    @(negedge clk);
    chk("t6_drop_rcache", 32'(rcache), 0);
    chk("t6_drop_busy", 32'(busy), 1);
    step();
    @(negedge clk);
    chk("t6_idle_busy", 32'(busy), 0);
    chk("t6_idle_rcache", 32'(rcache), 0);
    step();
    run(32'b1101, 4, "t6_next");
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_rcache", 32'(rcache), 0);
    step();
    @(negedge clk);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_waddr", 32'(waddr), 0);
    chk("t6_rst_toread", 32'(toread), 0);
    chk("t6_rst_full", 32'(mem_full), 0);
    step();
    rst = 1'b0; avail = '0;
    step();
    step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
